// File: rtl/uart_tx_pkg.sv
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared state encoding and framing constants for the UART
//                transmit serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN      = 1'b0;
    localparam logic PAR_ODD       = 1'b1;
    localparam int   STOP_BITS_MAX = 2;

endpackage

`default_nettype wire

// File: rtl/uart_parity_calc.sv
// ============================================================================
//  Module      : uart_parity_calc
//  Description : Even/odd parity bit for a DATA_WIDTH-bit word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);
    import uart_tx_pkg::*;

    logic w_xor;

    assign w_xor    = ^i_data;
    assign o_parity = (i_par_typ == PAR_EVEN) ? w_xor : ~w_xor;

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame_ser.sv
// ============================================================================
//  Module      : uart_tx_frame_ser
//  Description : UART frame serializer, one bit per clock, with a one-entry
//                holding buffer, optional parity and one or two stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame_ser #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);
    import uart_tx_pkg::*;

    localparam int                CNT_W      = $clog2(DATA_WIDTH);
    localparam int                STOP_CNT_W = $clog2(STOP_BITS_MAX);
    localparam logic [CNT_W-1:0]  c_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t               r_state;
    logic [DATA_WIDTH-1:0]   r_buf;
    logic                    r_buf_valid;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic [STOP_CNT_W-1:0]   r_stop_cnt;
    logic                    r_par_en;
    logic                    r_stop2;
    logic                    r_par_bit;
    logic                    r_tx;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_parity;
    logic                    w_last_stop;
    logic                    w_start;

    // Parity is taken from the buffered word as it moves into the shifter,
    // so the frame's parity is fixed before any data bit goes out.
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (r_buf),
        .i_par_typ (par_typ),
        .o_parity  (w_parity)
    );

    assign w_last_stop = (r_stop_cnt == STOP_CNT_W'(r_stop2));
    assign w_start     = r_buf_valid &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_last_stop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_stop_cnt  <= '0;
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_par_bit   <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_start) begin
                r_buf_valid <= 1'b0;
            end else if (data_valid && !r_buf_valid) begin
                r_buf       <= p_data;
                r_buf_valid <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
                START: begin
                    r_state <= DATA;
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_cnt   <= '0;
                end
                DATA: begin
                    if (r_cnt == c_LAST_BIT) begin
                        if (r_par_en) begin
                            r_state <= PARITY;
                            r_tx    <= r_par_bit;
                        end else begin
                            r_state    <= STOP;
                            r_tx       <= 1'b1;
                            r_stop_cnt <= '0;
                            r_done     <= ~r_stop2;
                        end
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    r_state    <= STOP;
                    r_tx       <= 1'b1;
                    r_stop_cnt <= '0;
                    r_done     <= ~r_stop2;
                end
                STOP: begin
                    if (w_last_stop) begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                        r_done     <= ((r_stop_cnt + 1'b1) == STOP_CNT_W'(r_stop2));
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

            // A frame start overrides whatever the state logic chose above,
            // which is what gives back-to-back frames with no idle gap.
            if (w_start) begin
                r_state   <= START;
                r_shift   <= r_buf;
                r_par_en  <= par_en;
                r_stop2   <= stop2;
                r_par_bit <= w_parity;
                r_cnt     <= '0;
                r_tx      <= 1'b0;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
            end
        end
    end

    assign data_ready = ~r_buf_valid;
    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame_ser.sv
// ============================================================================
//  Module      : tb_uart_tx_frame_ser
//  Description : Directed self-checking bench for uart_tx_frame_ser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_frame_ser;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       data_ready;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    logic [4:0] p_data5;
    logic       data_valid5;
    logic       data_ready5;
    logic       tx_out5;
    logic       busy5;
    logic       frame_done5;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_frame_ser #(.DATA_WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    uart_tx_frame_ser #(.DATA_WIDTH(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data5),
        .data_valid (data_valid5),
        .data_ready (data_ready5),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .tx_out     (tx_out5),
        .busy       (busy5),
        .frame_done (frame_done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        tick();
        check({tag, " idle tx"},   {31'd0, tx_out},     32'd1);
        check({tag, " idle busy"}, {31'd0, busy},       32'd0);
        check({tag, " idle done"}, {31'd0, frame_done}, 32'd0);
    endtask

    // exp_tx / exp_rdy bit i is the expected value in frame cycle i.
    task automatic run_frame(input string tag, input logic [31:0] exp_tx,
                             input logic [31:0] exp_rdy, input int len,
                             input int drop_at, input int flip_at);
        for (int i = 0; i < len; i++) begin
            tick();
            check($sformatf("%s[%0d] tx", tag, i),    {31'd0, tx_out},     {31'd0, exp_tx[i]});
            check($sformatf("%s[%0d] busy", tag, i),  {31'd0, busy},       32'd1);
            check($sformatf("%s[%0d] done", tag, i),  {31'd0, frame_done}, (i == len - 1) ? 32'd1 : 32'd0);
            check($sformatf("%s[%0d] ready", tag, i), {31'd0, data_ready}, {31'd0, exp_rdy[i]});
            if (i == drop_at) data_valid = 1'b0;
            if (i == flip_at) begin
                par_typ = ~par_typ;
                par_en  = ~par_en;
                stop2   = ~stop2;
            end
        end
    endtask

    task automatic accept8(input logic [7:0] d);
        p_data     = d;
        data_valid = 1'b1;
        tick();
        check("accept ready", {31'd0, data_ready}, 32'd0);
        data_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        p_data      = '0;
        data_valid  = 1'b0;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        stop2       = 1'b0;
        p_data5     = '0;
        data_valid5 = 1'b0;

        #12;
        check("reset tx",    {31'd0, tx_out},     32'd1);
        check("reset busy",  {31'd0, busy},       32'd0);
        check("reset done",  {31'd0, frame_done}, 32'd0);
        check("reset ready", {31'd0, data_ready}, 32'd1);
        check("reset tx5",   {31'd0, tx_out5},    32'd1);
        rst = 1'b0;

        // 0xA5, no parity, one stop bit: 10-cycle frame
        p_data     = 8'hA5;
        data_valid = 1'b1;
        tick();
        check("t1 accept ready", {31'd0, data_ready}, 32'd0);
        check("t1 accept tx",    {31'd0, tx_out},     32'd1);
        check("t1 accept busy",  {31'd0, busy},       32'd0);
        data_valid = 1'b0;
        run_frame("t1", 32'b11_0100_1010, 32'hFFFF_FFFF, 10, -1, -1);
        check_idle("t1");

        // 0xA5 with even then odd parity: 11-cycle frames
        par_en = 1'b1;
        accept8(8'hA5);
        run_frame("t2e", 32'b101_0100_1010, 32'hFFFF_FFFF, 11, -1, -1);
        check_idle("t2e");
        par_typ = 1'b1;
        accept8(8'hA5);
        run_frame("t2o", 32'b111_0100_1010, 32'hFFFF_FFFF, 11, -1, -1);
        check_idle("t2o");

        // 0x01 then 0x80 back-to-back, two stop bits, second word taken mid-frame
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop2      = 1'b1;
        accept8(8'h01);
        p_data     = 8'h80;
        data_valid = 1'b1;
        run_frame("t3a", 32'b110_0000_0010, 32'b000_0000_0001, 11, 1, -1);
        run_frame("t3b", 32'b111_0000_0000, 32'hFFFF_FFFF, 11, -1, -1);
        check_idle("t3");

        // reset during data bit 3 with a second word buffered
        stop2      = 1'b0;
        accept8(8'h00);
        p_data     = 8'h3C;
        data_valid = 1'b1;
        tick();
        check("t4 start tx", {31'd0, tx_out}, 32'd0);
        tick();
        data_valid = 1'b0;
        check("t4 buffered ready", {31'd0, data_ready}, 32'd0);
        tick();
        tick();
        tick();
        check("t4 bit3 tx",   {31'd0, tx_out}, 32'd0);
        check("t4 bit3 busy", {31'd0, busy},   32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4 async tx",    {31'd0, tx_out},     32'd1);
        check("t4 async busy",  {31'd0, busy},       32'd0);
        check("t4 async done",  {31'd0, frame_done}, 32'd0);
        check("t4 async ready", {31'd0, data_ready}, 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("t4 post[%0d] tx", i),   {31'd0, tx_out},     32'd1);
            check($sformatf("t4 post[%0d] busy", i), {31'd0, busy},       32'd0);
            check($sformatf("t4 post[%0d] done", i), {31'd0, frame_done}, 32'd0);
        end

        // accept on the first edge after reset, then toggle config mid-frame
        rst = 1'b1;
        #2;
        rst     = 1'b0;
        par_en  = 1'b1;
        par_typ = 1'b0;
        stop2   = 1'b0;
        accept8(8'hA5);
        run_frame("t5", 32'b101_0100_1010, 32'hFFFF_FFFF, 11, -1, 3);
        check_idle("t5");

        // DATA_WIDTH=5, 0x1B, odd parity: 0,1,1,0,1,1,1,1
        par_en      = 1'b1;
        par_typ     = 1'b1;
        stop2       = 1'b0;
        p_data5     = 5'h1B;
        data_valid5 = 1'b1;
        tick();
        check("t6 accept ready5", {31'd0, data_ready5}, 32'd0);
        data_valid5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp5;
            exp5 = 8'b1111_0110;
            tick();
            check($sformatf("t6[%0d] tx5", i),   {31'd0, tx_out5},     {31'd0, exp5[i]});
            check($sformatf("t6[%0d] busy5", i), {31'd0, busy5},       32'd1);
            check($sformatf("t6[%0d] done5", i), {31'd0, frame_done5}, (i == 7) ? 32'd1 : 32'd0);
        end
        tick();
        check("t6 idle tx5",   {31'd0, tx_out5}, 32'd1);
        check("t6 idle busy5", {31'd0, busy5},   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_frame_ser.md
UART_TX_FRAME_SER -- requirements
Module: uart_tx_frame_ser

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the data bits per frame (legal range 5..16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge, one edge per bit period.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port p_data, input, DATA_WIDTH bits: the parallel word to transmit.
REQ-005 The module SHALL have port data_valid, input, 1 bit: p_data is valid this cycle.
REQ-006 The module SHALL have port data_ready, output, 1 bit: the holding buffer can accept a word.
REQ-007 The module SHALL have port par_en, input, 1 bit: 1 inserts a parity bit.
REQ-008 The module SHALL have port par_typ, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-009 The module SHALL have port stop2, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-010 The module SHALL have port tx_out, output, 1 bit: the registered serial line (idle high).
REQ-011 The module SHALL have port busy, output, 1 bit: a frame is on the line.
REQ-012 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse in the last stop-bit cycle.

Function
REQ-013 A word SHALL be accepted into a one-entry holding buffer at a rising edge where data_valid=1 and data_ready=1.
REQ-014 data_ready SHALL equal NOT buffer_valid, driven from a register with no combinational path from data_valid.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-016 From IDLE with buffer_valid=1, the next edge SHALL enter START and move the buffer into the shift register.
REQ-017 That same edge SHALL clear buffer_valid and latch par_en, par_typ and stop2 for the frame.
REQ-018 Changes to par_en, par_typ or stop2 during a frame SHALL NOT affect that frame.
REQ-019 The line SHALL carry one bit per cycle: START=0.
REQ-020 DATA SHALL send DATA_WIDTH bits LSB first, with a bit counter of width $clog2(DATA_WIDTH).
REQ-021 PARITY SHALL be entered only when par_en=1 and SHALL send XOR(data) for even or NOT XOR(data) for odd.
REQ-022 STOP SHALL send 1 for one cycle, or two cycles when stop2=1.
REQ-023 The frame length SHALL be 1+DATA_WIDTH+par_en+1+stop2 cycles.
REQ-024 Latency: for a word accepted at edge k into an idle block, tx_out SHALL be 0 from edge k+1.
REQ-025 busy SHALL be 1 from the START cycle through the last stop cycle inclusive.
REQ-026 frame_done SHALL be 1 only during the last stop-bit cycle.
REQ-027 Back-to-back: if buffer_valid=1 in the last stop cycle, the next cycle SHALL be START with no idle gap, and busy SHALL stay 1.
REQ-028 A word SHALL be acceptable while a frame is in progress, because the buffer is independent of the shift register.
REQ-029 Once the buffer is full, data_ready SHALL remain 0 until the buffer is drained at the next frame start.
REQ-030 In IDLE, tx_out SHALL be 1.

Reset
REQ-031 rst=1 SHALL immediately force: tx_out=1, busy=0, frame_done=0, data_ready=1, state=IDLE, buffer_valid=0, counter=0.
REQ-032 rst asserted mid-frame SHALL abort the frame, discard the buffered word and send no truncated stop bits.
REQ-033 After rst deasserts, the block SHALL accept a word on the first edge.

Structure
REQ-034 Package uart_tx_pkg SHALL hold the state enum, the parity constants PAR_EVEN=0 and PAR_ODD=1, and the STOP_BITS_MAX constant.
REQ-035 Parity generation SHALL be a sub-module named uart_parity_calc, parametrised on DATA_WIDTH.

Verification
REQ-036 The bench SHALL cover: DATA_WIDTH=8, 0xA5, par_en=0, stop2=0 -> tx_out 0,1,0,1,0,0,1,0,1,1; busy high for 10 cycles; frame_done pulses in cycle 10.
REQ-037 The bench SHALL cover: 0xA5, par_en=1, par_typ=0 -> parity bit 0; with par_typ=1 -> parity bit 1; frame length 11.
REQ-038 The bench SHALL cover: 0x01 then 0x80 presented back-to-back, the second accepted mid-frame, with stop2=1 -> no idle gap; the second frame's START immediately follows its two stop bits; data_ready low until that START.
REQ-039 The bench SHALL cover: rst asserted during data bit 3 -> tx_out=1 and busy=0 asynchronously; the buffered word is discarded; no frame_done.
REQ-040 The bench SHALL cover: DATA_WIDTH=5, 0x1B, par_en=1, odd -> 0,1,1,0,1,1,1,1 (8 cycles).
REQ-041 The bench SHALL cover: par_typ toggled mid-frame -> the parity of the current frame is unchanged.
